game_clock_controller: RTL
==========================

Name: game_clock_controller

Overview:
- Sequences the scoreboard's game timing from the 1 Hz tick produced by the clock divider.
- Runs the period countdown clock (MM:SS), the shot clock and the period counter.
- Handles the start/pause, shot-reset and next-period operator commands, and drives the buzzer.
- Sits between the divider (tick source) and the display/segment-decoder logic; all logic runs on the 50 MHz clock, with the tick used as an enable.

Parameters:
- PERIOD_MINUTES, 10, period length in minutes (1..99); period starts at PERIOD_MINUTES:00.
- SHOT_SECONDS, 24, shot clock reload value (1..99).
- NUM_PERIODS, 4, number of periods in a game (1..7).
- BUZZER_TICKS, 2, buzzer duration in 1 Hz ticks (1..15).

Ports:
- clock_in, input, 1: 50 MHz system clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-high reset.
- tick_1hz, input, 1: single-cycle enable pulse, once per second, synchronous to clock_in.
- start_pause, input, 1: single-cycle debounced pulse; toggles run/pause.
- shot_reset, input, 1: single-cycle debounced pulse; reloads the shot clock.
- next_period, input, 1: single-cycle debounced pulse; advances to the next period.
- minutes, output, 7: game clock minutes.
- seconds, output, 6: game clock seconds (0..59).
- shot_seconds, output, 7: shot clock value.
- period, output, 3: current period, 1-based.
- running, output, 1: high only in state RUNNING.
- buzzer, output, 1: buzzer drive.
- game_over, output, 1: high only in state GAME_OVER.

Behaviour:
- Reset values (applied asynchronously):
  - state=IDLE, minutes=PERIOD_MINUTES, seconds=0, shot_seconds=SHOT_SECONDS, period=1.
  - running=0, buzzer=0, game_over=0, buzzer counter=0.
- States and transitions:
  - IDLE (clocks loaded, stopped): start_pause -> RUNNING.
  - RUNNING: start_pause -> PAUSED.
  - PAUSED: start_pause -> RUNNING.
  - PERIOD_END: next_period -> IDLE, with period+1 and both clocks reloaded. start_pause and shot_reset are ignored.
  - GAME_OVER: terminal; only reset exits. All commands are ignored.
  - next_period is ignored outside PERIOD_END.
- Tick processing, only when state==RUNNING at the start of the cycle and tick_1hz=1:
  - Game clock:
    - If seconds>0: seconds-1.
    - Else if minutes>0: minutes-1, seconds=59.
  - Shot clock: shot_seconds-1 if >0.
  - Game expiry: the decremented game clock equals 00:00.
    - Next state is GAME_OVER if period==NUM_PERIODS, else PERIOD_END.
    - Buzzer is started.
    - Shot clock is reloaded to SHOT_SECONDS.
  - Shot expiry (no game expiry): the decremented shot_seconds equals 0.
    - Next state is PAUSED.
    - Buzzer is started.
    - shot_seconds is reloaded to SHOT_SECONDS on the same edge.
- Latency:
  - Counters and the state update on the clock edge where tick_1hz is sampled high.
  - Outputs are registered and visible the next cycle.
  - Commands take effect on the edge where they are sampled.
- shot_reset in IDLE, RUNNING or PAUSED: shot_seconds=SHOT_SECONDS; no state change.
- Simultaneous events, same cycle:
  - Expiry beats start_pause: the expiry transition is taken and start_pause is dropped.
  - tick + start_pause in RUNNING without expiry: the tick decrement is applied and state goes to PAUSED.
  - tick + shot_reset in RUNNING: the reload wins (shot_seconds=SHOT_SECONDS, not decremented). Game clock decrement is still applied.
  - Game and shot expiry on the same tick: game expiry handling only; a single buzzer start.
- Buzzer:
  - Start sets buzzer=1 and loads the counter with BUZZER_TICKS.
  - Each subsequent tick_1hz (in any state) decrements the counter; buzzer drops when the counter reaches 0.
  - A new start while sounding restarts the count.
  - Buzzer keeps sounding into GAME_OVER until its count expires.
- Counters never wrap: no decrement below 0; minutes never decrements from 0.
- Reset mid-operation: all registers return immediately to their reset values; no buzzer glitch after release.

Test Plan:
All scenarios use PERIOD_MINUTES=1, SHOT_SECONDS=5, NUM_PERIODS=2, BUZZER_TICKS=2 unless noted.
- Reset then start_pause, then 1 tick:
  - Before the tick: 01:00, shot 5, period 1, running=1.
  - After the tick: 00:59, shot 4.
- Run 5 ticks:
  - Shot expiry; state PAUSED, running=0, shot=5, game 00:55, buzzer=1.
  - Buzzer still 1 after 1 more tick, 0 after 2 ticks.
- SHOT_SECONDS=99, run 60 ticks from start:
  - 00:00, state PERIOD_END, buzzer=1.
  - start_pause ignored.
  - next_period gives period=2, 01:00, shot 99, IDLE.
- In period 2 (SHOT_SECONDS=99), run to 00:00:
  - game_over=1, running=0.
  - next_period and start_pause have no effect.
  - Reset restores period=1 and 01:00.
- Same-cycle cases:
  - tick + shot_reset while RUNNING at shot 3: shot=5 and game clock decremented.
  - tick + start_pause at shot 1: shot-expiry PAUSED path; shot=5, buzzer=1.
- Assert reset mid-RUNNING with buzzer active:
  - Outputs are at reset values before the next clock edge.
  - Ticks while IDLE change no counter.

Source files
------------

// File: rtl/game_clock_controller.sv
// Game timing sequencer: period countdown (MM:SS), shot clock, period counter and buzzer,
// advanced by the 1 Hz tick enable and the operator command pulses.
module game_clock_controller #(
  parameter int PERIOD_MINUTES = 10,
  parameter int SHOT_SECONDS   = 24,
  parameter int NUM_PERIODS    = 4,
  parameter int BUZZER_TICKS   = 2
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start_pause,
  input  logic       shot_reset,
  input  logic       next_period,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic [6:0] shot_seconds,
  output logic [2:0] period,
  output logic       running,
  output logic       buzzer,
  output logic       game_over,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RUNNING    = 3'd1;
  localparam logic [2:0] PAUSED     = 3'd2;
  localparam logic [2:0] PERIOD_END = 3'd3;
  localparam logic [2:0] GAME_OVER  = 3'd4;

  localparam logic [6:0] MIN_LOAD    = 7'(PERIOD_MINUTES);
  localparam logic [6:0] SHOT_LOAD   = 7'(SHOT_SECONDS);
  localparam logic [2:0] LAST_PERIOD = 3'(NUM_PERIODS);
  localparam logic [3:0] BUZZ_LOAD   = 4'(BUZZER_TICKS);

  logic [2:0] state;
  logic [3:0] buzz_cnt;
  logic [3:0] buzz_nxt;
  logic [6:0] dec_min;
  logic [5:0] dec_sec;
  logic [6:0] dec_shot;
  logic       tick_run;
  logic       game_exp;
  logic       shot_exp;

  // Saturating decrements; expiry is judged on the already-decremented values.
  always_comb begin
    dec_min = minutes;
    dec_sec = seconds;
    if (seconds != 6'd0) begin
      dec_sec = seconds - 6'd1;
    end else if (minutes != 7'd0) begin
      dec_min = minutes - 7'd1;
      dec_sec = 6'd59;
    end
    dec_shot = (shot_seconds != 7'd0) ? shot_seconds - 7'd1 : shot_seconds;
    tick_run = (state == RUNNING) && tick_1hz;
    game_exp = tick_run && (dec_min == 7'd0) && (dec_sec == 6'd0);
    shot_exp = tick_run && !game_exp && !shot_reset && (dec_shot == 7'd0);
    buzz_nxt = buzz_cnt;
    if (game_exp || shot_exp) begin
      buzz_nxt = BUZZ_LOAD;
    end else if (tick_1hz && (buzz_cnt != 4'd0)) begin
      buzz_nxt = buzz_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      minutes      <= MIN_LOAD;
      seconds      <= 6'd0;
      shot_seconds <= SHOT_LOAD;
      period       <= 3'd1;
      buzz_cnt     <= 4'd0;
      buzzer       <= 1'b0;
    end else begin
      buzz_cnt <= buzz_nxt;
      buzzer   <= (buzz_nxt != 4'd0);
      case (state)
        IDLE, PAUSED: begin
          if (start_pause) state <= RUNNING;
          if (shot_reset) shot_seconds <= SHOT_LOAD;
        end
        RUNNING: begin
          if (tick_1hz) begin
            minutes      <= dec_min;
            seconds      <= dec_sec;
            shot_seconds <= (shot_reset || game_exp || shot_exp) ? SHOT_LOAD : dec_shot;
          end else if (shot_reset) begin
            shot_seconds <= SHOT_LOAD;
          end
          // Expiry outranks a same-cycle start_pause.
          if (game_exp) begin
            state <= (period == LAST_PERIOD) ? GAME_OVER : PERIOD_END;
          end else if (shot_exp || start_pause) begin
            state <= PAUSED;
          end
        end
        PERIOD_END: begin
          if (next_period) begin
            state        <= IDLE;
            period       <= period + 3'd1;
            minutes      <= MIN_LOAD;
            seconds      <= 6'd0;
            shot_seconds <= SHOT_LOAD;
          end
        end
        GAME_OVER: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign running   = (state == RUNNING);
  assign game_over = (state == GAME_OVER);
  assign fsm_state = state;

endmodule
